// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream boot loader for nRisc instruction/data memories
// Frames: header, address, length (0 = 256), payload; a RUN header releases the CPU.
module prog_loader #(
  parameter int                   ADDR_WIDTH = 8,
  parameter int                   DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] CMD_INSTR = 8'h49,
  parameter logic [DATA_WIDTH-1:0] CMD_DATA  = 8'h44,
  parameter logic [DATA_WIDTH-1:0] CMD_RUN   = 8'hFF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] InDado,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [ADDR_WIDTH-1:0] InstrEndereco,
  output logic [DATA_WIDTH-1:0] InstrDado,
  output logic                  InstrWrite,
  output logic [ADDR_WIDTH-1:0] DadoEndereco,
  output logic [DATA_WIDTH-1:0] DadoEscr,
  output logic                  MemWrite,
  output logic                  CpuReset,
  output logic                  Busy,
  output logic                  Error
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_RUN  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic                  target_d_q, target_d_d;   // 1 = data memory, 0 = instruction memory
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0] instr_addr_q, dado_addr_q;
  logic [DATA_WIDTH-1:0] instr_data_q, dado_data_q;
  logic                  instr_we_q, mem_we_q;
  logic                  cpu_reset_q, error_q;

  logic                  accept;
  logic                  wr_instr, wr_data;
  logic                  hdr_bad, hdr_run;
  logic                  in_ready_c, busy_c;
  logic [ADDR_WIDTH-1:0] byte_as_addr;

  assign byte_as_addr = InDado[ADDR_WIDTH-1:0];
  assign accept       = InValid && in_ready_c;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      target_d_q <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      target_d_q <= target_d_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d_d = target_d_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (InDado == CMD_INSTR) begin
            state_d    = S_ADDR;
            target_d_d = 1'b0;
          end else if (InDado == CMD_DATA) begin
            state_d    = S_ADDR;
            target_d_d = 1'b1;
          end else if (InDado == CMD_RUN) begin
            state_d = S_RUN;
          end
        end
      end
      S_ADDR: begin
        if (accept) begin
          ptr_d   = byte_as_addr;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (accept) begin
          cnt_d   = (byte_as_addr == '0) ? CNT_FULL : {1'b0, byte_as_addr};
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_ONE) begin
            state_d = S_IDLE;
          end
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Ready drops combinationally under reset so nothing is consumed while the loader is held.
  always_comb begin
    in_ready_c = 1'b0;
    busy_c     = 1'b0;
    wr_instr   = 1'b0;
    wr_data    = 1'b0;
    hdr_bad    = 1'b0;
    hdr_run    = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_c = Reset;
        hdr_run    = InValid && Reset && (InDado == CMD_RUN);
        hdr_bad    = InValid && Reset && (InDado != CMD_RUN) &&
                     (InDado != CMD_INSTR) && (InDado != CMD_DATA);
      end
      S_ADDR, S_LEN: begin
        in_ready_c = Reset;
        busy_c     = 1'b1;
      end
      S_DATA: begin
        in_ready_c = Reset;
        busy_c     = 1'b1;
        wr_instr   = InValid && Reset && !target_d_q;
        wr_data    = InValid && Reset && target_d_q;
      end
      default: begin
        in_ready_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      instr_addr_q <= '0;
      instr_data_q <= '0;
      instr_we_q   <= 1'b0;
      dado_addr_q  <= '0;
      dado_data_q  <= '0;
      mem_we_q     <= 1'b0;
      cpu_reset_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      instr_we_q <= wr_instr;
      mem_we_q   <= wr_data;
      if (wr_instr) begin
        instr_addr_q <= ptr_q;
        instr_data_q <= InDado;
      end
      if (wr_data) begin
        dado_addr_q <= ptr_q;
        dado_data_q <= InDado;
      end
      if (hdr_run) begin
        cpu_reset_q <= 1'b1;
      end
      if (hdr_bad) begin
        error_q <= 1'b1;
      end
    end
  end

  assign InReady       = in_ready_c;
  assign Busy          = busy_c;
  assign InstrEndereco = instr_addr_q;
  assign InstrDado     = instr_data_q;
  assign InstrWrite    = instr_we_q;
  assign DadoEndereco  = dado_addr_q;
  assign DadoEscr      = dado_data_q;
  assign MemWrite      = mem_we_q;
  assign CpuReset      = cpu_reset_q;
  assign Error         = error_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream boot loader for the 8-bit nRisc system.
- Accepts a framed byte stream over a valid/ready handshake and writes it into instruction memory and data memory through their write ports.
- Holds the processor in reset while loading, and releases it on a RUN command.
- Replaces file preloading in synthesizable builds; sits between the host/UART byte source and the MemoriaInstrucao/MemoriaDados write ports.

Parameters:
- ADDR_WIDTH, 8, memory address width (256 locations).
- DATA_WIDTH, 8, byte/word width.
- CMD_INSTR, 8'h49, header selecting instruction memory.
- CMD_DATA, 8'h44, header selecting data memory.
- CMD_RUN, 8'hFF, header releasing the CPU.

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-low reset (sampled on posedge Clock).
- InDado  in  8  stream byte.
- InValid  in  1  InDado valid.
- InReady  out  1  loader accepts a byte this cycle.
- InstrEndereco  out  8  instruction memory write address.
- InstrDado  out  8  instruction memory write data.
- InstrWrite  out  1  instruction memory write strobe, 1 cycle.
- DadoEndereco  out  8  data memory write address.
- DadoEscr  out  8  data memory write data.
- MemWrite  out  1  data memory write strobe, 1 cycle.
- CpuReset  out  1  active-low reset to nRisc; 0 while loading.
- Busy  out  1  segment in progress (state not IDLE/RUN).
- Error  out  1  sticky: unknown header received.

Behaviour:
- Handshake: a byte is accepted at a posedge where InValid=1 and InReady=1. InReady is combinational: 1 in IDLE/ADDR/LEN/DATA, 0 in RUN and while Reset=0. InDado is ignored when not accepted.
- Reset (Reset=0 at posedge): state=IDLE; all strobes 0; addresses/data 0; CpuReset=0; Busy=0; Error=0; segment target cleared. Applies mid-segment: any partial segment is abandoned, and writes already done remain in memory.
- FSM:
  - IDLE:
    - accept CMD_INSTR -> ADDR, target=I.
    - accept CMD_DATA -> ADDR, target=D.
    - accept CMD_RUN -> RUN.
    - accept any other byte -> Error=1, stay IDLE, byte dropped.
  - ADDR: accept -> load 8-bit address pointer; -> LEN.
  - LEN: accept -> load 9-bit remaining count; 0 encodes 256; -> DATA.
  - DATA: each accept issues one write at the pointer, then pointer += 1 (mod 256, wraps 8'hFF->8'h00) and count -= 1. When the count reaches 0 on the accepted byte -> IDLE.
  - RUN: CpuReset=1; InReady=0; terminal until Reset. Error does not block RUN.
- Write timing: strobes, address and data are registered. For a byte accepted at edge k, InstrWrite/MemWrite is 1 for exactly the cycle between edges k and k+1, with the address and data stable in that cycle. Only the selected target strobes; never both.
- Back-to-back bytes (InValid held 1) give one write per cycle, with no bubbles.
- Address/data outputs hold their last value when no strobe is active.
- Busy=1 in ADDR, LEN, DATA.
- CpuReset changes 0->1 on the edge that accepts CMD_RUN and is registered.
- Error is sticky until Reset.
- No command byte is recognised in ADDR/LEN/DATA; 8'hFF there is plain data.

Test Plan:
- Reset=0 for 2 cycles, then 1 -> CpuReset=0, InReady=1, Busy=0, Error=0, no strobes.
- Stream 49,10,03,A1,B2,C3 with InValid continuous -> InstrWrite pulses in 3 consecutive cycles at addresses 10,11,12 with data A1,B2,C3; MemWrite stays 0; Busy falls after C3.
- Stream 44,FE,03,01,02,03 -> MemWrite writes 01@FE, 02@FF, 03@00 (wrap).
- Stream 44,00,00 followed by 256 bytes -> exactly 256 MemWrite pulses covering 00..FF, then IDLE.
- Unknown header 55, then 49,00,01,7F, then FF -> Error=1, instruction write 7F@00, then CpuReset=1 and InReady=0; further InValid bytes cause no strobes.
- Reset=0 asserted after 2 data bytes of a 4-byte segment, then stream FF -> no further writes from the old segment, Error=0, RUN entered with CpuReset=1.
